layer_sequencer: RTL

Controller for one fully-connected layer of neuron instances. Loads each neuron's weight memory from a single 32-bit weight stream, broadcasts one input vector of `numWeight` samples to all neurons, and collects every neuron's `outvalid`/`out` pair. It then serialises the `numNeuron` results as a stream to the next layer. It sits between the upstream layer (or input buffer) and the neuron array, and is the only driver of the neurons' input and configuration ports.

---
 rtl/layer_seq_pkg.sv | 28 ++
 rtl/layer_sequencer_if.sv | 54 +++++
 rtl/neuron_result_buf.sv | 60 ++++++
 rtl/layer_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_seq_pkg
// Description : Shared types and helpers for the fully-connected layer
//               sequencer: controller state encoding and counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_seq_pkg;

  // Controller states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    DRAIN  = 3'd4
  } seq_state_t;

  // Width of the neuron-side weight and configuration buses.
  localparam int c_WORD_W = 32;

  // Bits needed to hold any value 0..n (counter that may reach its limit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer_if
// Description : Bus bundle around the layer sequencer: weight stream, input
//               sample stream, neuron-array broadcast/collect bus and result
//               stream.
//   slave  : sequencer side (accepts streams, drives neurons, emits results)
//   master : environment side (upstream source, neuron array, downstream sink)
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_sequencer_if #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
);
  // Weight stream
  logic                           w_valid;
  logic                           w_ready;
  logic [31:0]                    w_data;
  // Input sample stream
  logic                           in_valid;
  logic                           in_ready;
  logic [dataWidth-1:0]           in_data;
  // Neuron array bus
  logic [dataWidth-1:0]           n_myinput;
  logic                           n_myinputValid;
  logic                           n_weightValid;
  logic [31:0]                    n_weightValue;
  logic                           n_biasValid;
  logic [31:0]                    config_layer_num;
  logic [31:0]                    config_neuron_num;
  logic [numNeuron-1:0]           n_outvalid;
  logic [numNeuron*dataWidth-1:0] n_out;
  // Result stream
  logic                           out_valid;
  logic                           out_ready;
  logic [dataWidth-1:0]           out_data;
  logic                           out_last;

  modport slave (
    input  w_valid, w_data, in_valid, in_data, n_outvalid, n_out, out_ready,
    output w_ready, in_ready, n_myinput, n_myinputValid, n_weightValid,
           n_weightValue, n_biasValid, config_layer_num, config_neuron_num,
           out_valid, out_data, out_last
  );

  modport master (
    output w_valid, w_data, in_valid, in_data, n_outvalid, n_out, out_ready,
    input  w_ready, in_ready, n_myinput, n_myinputValid, n_weightValid,
           n_weightValue, n_biasValid, config_layer_num, config_neuron_num,
           out_valid, out_data, out_last
  );

endinterface
`default_nettype wire

// File: rtl/neuron_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : neuron_result_buf
// Description : One result slot and one sticky "captured" bit per neuron.
//               A slot is written only on the first capture strobe after a
//               clear; later strobes for that neuron are ignored.
// Ports       : clk, rst (async, active-low)
//               clr          - clear all sticky bits (slots keep old data)
//               cap_en[k]    - capture strobe for neuron k
//               cap_data     - flat results, neuron k at [k*DATA_WIDTH +: DATA_WIDTH]
//               rd_idx       - read index, rd_data = slot[rd_idx]
//               all_set      - every sticky bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_result_buf #(
  parameter int NUM_NEURON = 30,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic [NUM_NEURON-1:0]            cap_en,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] cap_data,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             all_set
);

  logic [NUM_NEURON-1:0]                 r_sticky;
  logic [NUM_NEURON-1:0][DATA_WIDTH-1:0] r_slot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sticky <= '0;
      r_slot   <= '0;
    end else begin
      for (int k = 0; k < NUM_NEURON; k++) begin
        if (clr) begin
          r_sticky[k] <= 1'b0;
        end else if (cap_en[k] && !r_sticky[k]) begin
          r_sticky[k] <= 1'b1;
          r_slot[k]   <= cap_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Compare-based read mux keeps the index width independent of slot count.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_NEURON; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = r_slot[k];
    end
  end

  assign all_set = &r_sticky;

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer
// Description : Controller for one fully-connected layer. Loads every
//               neuron's weights from one 32-bit stream, broadcasts one input
//               vector to all neurons, collects each neuron's result once and
//               serialises the results to the next layer.
// Ports       : clk, rst (async, active-low)
//               cmd_load, start    - command pulses, honoured in IDLE only
//               bus (slave)        - weight/input streams, neuron bus, results
//               weights_loaded     - sticky, set after a complete load
//               busy               - controller not idle
//               done               - one-cycle pulse after the last result
//               err                - sticky WAIT watchdog error
// Options     : LAYER_SEQ_TIMEOUT_EN - enables the WAIT watchdog; without it
//               err is tied low and WAIT has no time limit.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
  parameter int layerNo    = 1,
  parameter int numNeuron  = 30,
  parameter int numWeight  = 784,
  parameter int dataWidth  = 16,
  parameter int WAIT_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_load,
  input  logic              start,
  layer_sequencer_if.slave  bus,
  output logic              weights_loaded,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import layer_seq_pkg::*;

  localparam int c_WCW = cnt_width(numWeight);
  localparam int c_NCW = cnt_width(numNeuron);

  seq_state_t r_state, w_state_nxt;

  logic [c_WCW-1:0]     r_wcnt;        // weight index in LOAD_W, sample count in STREAM
  logic [c_NCW-1:0]     r_ncnt;        // neuron index in LOAD_W, result index in DRAIN
  logic                 r_w_ready;
  logic                 r_in_ready;
  logic                 r_wvalid;
  logic [c_WORD_W-1:0]  r_wvalue;
  logic [c_WORD_W-1:0]  r_cfg_neuron;
  logic                 r_ivalid;
  logic [dataWidth-1:0] r_idata;
  logic                 r_loaded;
  logic                 r_done;

  logic                 w_w_hs, w_in_hs, w_out_hs;
  logic                 w_last_word, w_last_neuron, w_last_sample;
  logic                 w_all_set, w_clr;
  logic                 w_err_set;
  logic [numNeuron-1:0] w_cap_en;
  logic [dataWidth-1:0] w_rd_data;

  // Ready registers are only high in their own state, so a handshake never
  // needs a separate state qualifier.
  assign w_w_hs        = r_w_ready  && bus.w_valid;
  assign w_in_hs       = r_in_ready && bus.in_valid;
  assign w_out_hs      = (r_state == DRAIN) && bus.out_ready;
  assign w_last_word   = (r_wcnt == c_WCW'(numWeight - 1));
  assign w_last_sample = w_last_word;
  assign w_last_neuron = (r_ncnt == c_NCW'(numNeuron - 1));

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int c_TCW = cnt_width(WAIT_LIMIT);
  logic [c_TCW-1:0] r_wait_cnt;
  logic             r_err;
`endif

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_load)               w_state_nxt = LOAD_W;  // load wins over start
        else if (start && r_loaded) w_state_nxt = STREAM;
      end
      LOAD_W: begin
        if (w_w_hs && w_last_word && w_last_neuron) w_state_nxt = IDLE;
      end
      STREAM: begin
        if (w_in_hs && w_last_sample) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_all_set) begin
          w_state_nxt = DRAIN;
        end
`ifdef LAYER_SEQ_TIMEOUT_EN
        else if (r_wait_cnt == c_TCW'(WAIT_LIMIT - 1)) begin
          w_state_nxt = IDLE;
          w_err_set   = 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (w_out_hs && w_last_neuron) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_wcnt       <= '0;
      r_ncnt       <= '0;
      r_w_ready    <= 1'b0;
      r_in_ready   <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wvalue     <= '0;
      r_cfg_neuron <= '0;
      r_ivalid     <= 1'b0;
      r_idata      <= '0;
      r_loaded     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_w_ready  <= (w_state_nxt == LOAD_W);
      r_in_ready <= (w_state_nxt == STREAM);
      r_wvalid   <= w_w_hs;
      r_ivalid   <= w_in_hs;
      r_done     <= w_out_hs && w_last_neuron;

      if (w_w_hs) begin
        r_wvalue     <= bus.w_data;
        r_cfg_neuron <= c_WORD_W'(r_ncnt);
      end
      if (w_in_hs) r_idata <= bus.in_data;

      if (r_state == IDLE && cmd_load) r_loaded <= 1'b0;
      else if (r_state == LOAD_W && w_state_nxt == IDLE) r_loaded <= 1'b1;

      case (r_state)
        LOAD_W: begin
          if (w_w_hs) begin
            if (w_last_word) begin
              r_wcnt <= '0;
              r_ncnt <= w_last_neuron ? '0 : r_ncnt + 1'b1;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (w_in_hs) r_wcnt <= w_last_sample ? '0 : r_wcnt + 1'b1;
        end
        DRAIN: begin
          if (w_out_hs) r_ncnt <= w_last_neuron ? '0 : r_ncnt + 1'b1;
        end
        default: begin
          r_wcnt <= '0;
          r_ncnt <= '0;
        end
      endcase
    end
  end

`ifdef LAYER_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 1'b1 : '0;
      if (w_err_set) r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // A zero watchdog limit would be meaningless; flag it at elaboration by
  // producing an empty, clearly named block that reviewers can search for.
  if (WAIT_LIMIT < 1) begin : g_bad_wait_limit
  end

  // ---------------------------------------------------------- result buffer
  // Sticky bits are cleared exactly on the IDLE->STREAM transition so a new
  // inference never sees results from the previous one.
  assign w_clr    = (r_state == IDLE) && (w_state_nxt == STREAM);
  assign w_cap_en = (r_state == WAIT) ? bus.n_outvalid : '0;

  neuron_result_buf #(
    .NUM_NEURON (numNeuron),
    .DATA_WIDTH (dataWidth),
    .IDX_W      (c_NCW)
  ) u_result_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .cap_en   (w_cap_en),
    .cap_data (bus.n_out),
    .rd_idx   (r_ncnt),
    .rd_data  (w_rd_data),
    .all_set  (w_all_set)
  );

  // ---------------------------------------------------------------- outputs
  assign bus.w_ready           = r_w_ready;
  assign bus.in_ready          = r_in_ready;
  assign bus.n_weightValid     = r_wvalid;
  assign bus.n_weightValue     = r_wvalue;
  assign bus.config_neuron_num = r_cfg_neuron;
  assign bus.config_layer_num  = c_WORD_W'(layerNo);
  assign bus.n_biasValid       = 1'b0;
  assign bus.n_myinput         = r_idata;
  assign bus.n_myinputValid    = r_ivalid;
  assign bus.out_valid         = (r_state == DRAIN);
  assign bus.out_data          = (r_state == DRAIN) ? w_rd_data : '0;
  assign bus.out_last          = (r_state == DRAIN) && w_last_neuron;

  assign weights_loaded = r_loaded;
  assign busy           = (r_state != IDLE);
  assign done           = r_done;

endmodule
`default_nettype wire
